// File: rtl/multicycle_seq_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_seq_ctrl
//
// Sequencer for the multi-cycle, single-issue MIPS datapath. It steps each
// instruction through FETCH / DECODE / EXEC / MEM / WB and drives the
// per-cycle datapath write enables and memory requests. Static decode stays in
// the combinational decoder. This block only latches the decoder's
// MemRead / MemWrite / RegWrite in DECODE, times out stalled memory accesses,
// and counts retired instructions.
//
// Handshake: imemReq / dmemReq are held high for every cycle spent in
// FETCH / MEM. The matching ack completes the access in the cycle in which it
// is seen together with its request. An ack that arrives while its request is
// low is ignored. irWrite, pcWrite and mdrWrite are qualified by that
// same-cycle ack.
//
// Parameters
//   MEM_TIMEOUT  cycles allowed for an ack before FAULT (0 = wait forever)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   run                     level; permits fetching the next instruction
//   clearFault              pulse; returns FAULT to IDLE
//   opcode                  IR[31:26], stable from DECODE onward
//   ctrlMemRead/Write,
//   ctrlRegWrite            decoder outputs for the current IR
//   imemReq / imemAck       instruction fetch request / data valid
//   dmemReq / dmemWe /
//   dmemAck                 data request, 1=store 0=load, ack
//   irWrite, pcWrite,
//   aluOutWrite, mdrWrite,
//   regWriteEn              datapath write strobes
//   fault, faultCode        FAULT indication; 01 illegal op, 10 imem timeout,
//                           11 dmem timeout
//   state                   current FSM state (IDLE=0 .. FAULT=6)
//   instret                 retired instruction count; wraps to 0
// -----------------------------------------------------------------------------
module multicycle_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clearFault,
    input  logic [5:0]       opcode,
    input  logic             ctrlMemRead,
    input  logic             ctrlMemWrite,
    input  logic             ctrlRegWrite,
    output logic             imemReq,
    input  logic             imemAck,
    output logic             dmemReq,
    output logic             dmemWe,
    input  logic             dmemAck,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             aluOutWrite,
    output logic             mdrWrite,
    output logic             regWriteEn,
    output logic             fault,
    output logic [1:0]       faultCode,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // The wait counter only has to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        code_q, code_d;
    logic [CNT_W-1:0]  instret_q;
    logic              mem_read_q, mem_write_q, reg_write_q;
    logic              latch_ctrl;
    logic              retire;
    logic              wait_expired;

    function automatic logic legal_opcode(input logic [5:0] op);
        case (op)
            6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: legal_opcode = 1'b1;
            default:                           legal_opcode = 1'b0;
        endcase
    endfunction

    // This cycle is the last one in which an ack is still accepted.
    assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        code_d      = code_q;
        latch_ctrl  = 1'b0;
        retire      = 1'b0;
        imemReq     = 1'b0;
        dmemReq     = 1'b0;
        dmemWe      = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        aluOutWrite = 1'b0;
        mdrWrite    = 1'b0;
        regWriteEn  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imemReq = 1'b1;
                if (imemAck) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                    code_d  = 2'b10;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (legal_opcode(opcode)) begin
                    latch_ctrl = 1'b1;
                    state_d    = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                    code_d  = 2'b01;
                end
            end
            S_EXEC: begin
                aluOutWrite = 1'b1;
                if (mem_read_q || mem_write_q) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else if (reg_write_q) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                dmemReq = 1'b1;
                dmemWe  = mem_write_q;
                if (dmemAck) begin
                    if (mem_write_q) begin
                        retire = 1'b1;
                    end else begin
                        mdrWrite = 1'b1;
                        state_d  = S_WB;
                    end
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                    code_d  = 2'b11;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                regWriteEn = 1'b1;
                retire     = 1'b1;
            end
            S_FAULT: begin
                if (clearFault) begin
                    state_d = S_IDLE;
                    code_d  = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Retirement always completes the instruction; run only decides
        // whether the next one is fetched.
        if (retire) begin
            state_d = run ? S_FETCH : S_IDLE;
            wait_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            code_q      <= 2'b00;
            instret_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            code_q  <= code_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (latch_ctrl) begin
                mem_read_q  <= ctrlMemRead;
                mem_write_q <= ctrlMemWrite;
                reg_write_q <= ctrlRegWrite;
            end
        end
    end

    assign state     = state_q;
    assign fault     = (state_q == S_FAULT);
    assign faultCode = code_q;
    assign instret   = instret_q;

endmodule
